reaction_sequencer: RTL and testbench
=====================================

# reaction_sequencer

Top-level controller for the FPGA reaction timer. Sequences one trial: it latches a random delay value, waits that delay, lights the stimulus LED, and measures reaction time in millisecond ticks until the player presses. It detects false starts and timeouts, and optionally tracks the best score. It sits between the debounced button front-end and the random source on one side, and the 7-segment display driver on the other.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles per measurement tick (1 ms at 50 MHz); must be ≥ 2.
- DELAY_UNIT, 250: ticks per random-delay step.
- DELAY_W, 4: width of random delay input.
- RT_W, 10: reaction-count width; saturation value is 2^RT_W−1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clock
- start_btn  in  1  single-cycle synchronous pulse, debounced upstream
- react_btn  in  1  single-cycle synchronous pulse, debounced upstream
- rand_val  in  DELAY_W  random delay step, sampled on accepted start
- led  out  1  stimulus LED, high only in REACT
- busy  out  1  high in DELAY or REACT
- result  out  RT_W  last measured reaction count, held until next accepted start
- result_valid  out  1  one-cycle pulse when result updates
- foul  out  1  level, high in FOUL state
- timeout  out  1  level, set when last result saturated; cleared on accepted start
- best  out  RT_W  best score (BEST_TIME_EN only)
- new_best  out  1  one-cycle pulse alongside result_valid when best improved (BEST_TIME_EN only)

## Operation
- States: IDLE, DELAY, REACT, SHOW, FOUL. Reset → IDLE.
- Reset values: led=0, busy=0, result=0, result_valid=0, foul=0, timeout=0, best=all ones, new_best=0. Reset mid-trial aborts immediately to IDLE.
- Tick prescaler counts 0..TICK_DIV−1. tick is high in the cycle where prescaler = TICK_DIV−1. The prescaler clears on every state entry.
- IDLE/SHOW/FOUL + start_btn → DELAY:
  - latch d = rand_val;
  - clear delay counter, result, timeout, foul.
- DELAY:
  - total ticks = (d+1)·DELAY_UNIT, counted as a unit counter plus a step counter (no multiplier);
  - when the last tick occurs → REACT;
  - react_btn → FOUL (no result_valid);
  - react_btn wins over expiry in the same cycle;
  - start_btn ignored.
- REACT:
  - led=1; reaction counter rt clears on entry and increments on each tick;
  - react_btn → SHOW with result=rt and result_valid pulse;
  - if rt would exceed 2^RT_W−1 → SHOW with result=2^RT_W−1, timeout=1, result_valid pulse;
  - react_btn wins over saturation in the same cycle (result = current rt, timeout=0);
  - start_btn ignored.
- SHOW and FOUL hold all outputs until start_btn.
- react_btn in IDLE/SHOW/FOUL is ignored.
- All counters are unsigned and sized to never wrap before their terminal compare.

## Timing
- start_btn high at edge E → busy=1 after E, and the first DELAY cycle follows E.
- The DELAY→REACT transition occurs at the edge ending the cycle with the final tick. Delay length = (d+1)·DELAY_UNIT·TICK_DIV cycles exactly.
- led rises at the first REACT cycle N (registered output).
- react_btn sampled at edge ending cycle k ≥ N → result = number of ticks in cycles N..k−1. result, result_valid, and led=0 all become visible in the same cycle after that edge.
- result_valid and new_best are exactly 1 cycle wide.

## Configuration
- BEST_TIME_EN defined:
  - the best register is updated at result_valid when timeout=0 and result < best;
  - new_best pulses with result_valid on that update;
  - best persists across trials and clears only on reset.
- BEST_TIME_EN undefined:
  - no best register; best is tied to all ones and new_best to 0.

## Test plan
(TICK_DIV=4, DELAY_UNIT=2, RT_W=4 unless noted.)
- Nominal trial: rand_val=3 with start pulse.
  - led rises exactly 32 cycles after the start edge.
  - A react pulse 21 cycles after led rise → result=5, single result_valid pulse, led=0, state SHOW.
- False start: react pulse 10 cycles into DELAY → foul=1, led never rises, no result_valid. A later start clears foul and enters DELAY.
- Timeout: no react → result=15 at 64 cycles after led rise, timeout=1, result_valid pulse. The next start clears timeout.
- Simultaneous events, both must hold:
  - react in the final DELAY tick cycle → FOUL;
  - react in the REACT saturation cycle → result=15, timeout=0;
  - start pulses during DELAY/REACT are ignored.
- Reset mid-REACT: assert reset asynchronously while led=1 → led=0, busy=0, result=0 immediately; IDLE after release.
- BEST_TIME_EN: trials with results 9, 6, 7 → best=9, 6, 6 and new_best pulses on the first two only. With the macro undefined, best stays at 15.

Source files
------------

// File: rtl/reaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_sequencer
// Brief    : Reaction-timer trial controller. Latches a random delay on an
//            accepted start, waits (d+1)*DELAY_UNIT ticks, lights the
//            stimulus LED and counts millisecond ticks until the player
//            reacts. Flags false starts (FOUL) and saturated results
//            (timeout).
// Options  : BEST_TIME_EN - when defined, keeps a best-score register and
//            pulses new_best whenever a non-timeout result beats it.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int DELAY_UNIT = 250,
    parameter int DELAY_W    = 4,
    parameter int RT_W       = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               react_btn,
    input  logic [DELAY_W-1:0] rand_val,
    output logic               led,
    output logic               busy,
    output logic [RT_W-1:0]    result,
    output logic               result_valid,
    output logic               foul,
    output logic               timeout,
    output logic [RT_W-1:0]    best,
    output logic               new_best
);

    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_unit_w  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_unit_w-1:0]  c_unit_last  = c_unit_w'(DELAY_UNIT - 1);
    localparam logic [RT_W-1:0]      c_rt_max     = '1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_delay = 3'd1;
    localparam logic [2:0] c_st_react = 3'd2;
    localparam logic [2:0] c_st_show  = 3'd3;
    localparam logic [2:0] c_st_foul  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_presc_w-1:0] r_presc;
    logic [c_unit_w-1:0]  r_unit;
    logic [DELAY_W-1:0]   r_step;
    logic [DELAY_W-1:0]   r_d;
    logic [RT_W-1:0]      r_rt;
    logic [RT_W-1:0]      r_result;
    logic                 r_result_valid;
    logic                 r_timeout;
    logic                 r_led;
    logic                 r_busy;
    logic                 r_foul;

    logic w_tick;
    logic w_enter;
    logic w_start_ok;
    logic w_delay_done;
    logic w_rt_sat;
    logic w_react_hit;

    assign w_tick       = (r_presc == c_presc_last);
    assign w_enter      = (w_state_nxt != r_state);
    assign w_start_ok   = start_btn && ((r_state == c_st_idle) ||
                                        (r_state == c_st_show) ||
                                        (r_state == c_st_foul));
    // The last tick of the last unit of the last step ends the delay.
    assign w_delay_done = w_tick && (r_unit == c_unit_last) && (r_step == r_d);
    // One more tick would overflow the reaction counter.
    assign w_rt_sat     = w_tick && (r_rt == c_rt_max);
    assign w_react_hit  = (r_state == c_st_react) && react_btn;

    // State register; reset aborts any trial straight back to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; react_btn takes priority over delay expiry/saturation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_show, c_st_foul: begin
                if (start_btn) w_state_nxt = c_st_delay;
            end
            c_st_delay: begin
                if (react_btn)         w_state_nxt = c_st_foul;
                else if (w_delay_done) w_state_nxt = c_st_react;
            end
            c_st_react: begin
                if (react_btn || w_rt_sat) w_state_nxt = c_st_show;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Tick prescaler, restarted on every state entry so timing is edge-exact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_enter || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Delay bookkeeping: unit counter inside step counter replaces a multiplier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d    <= '0;
            r_unit <= '0;
            r_step <= '0;
        end else if (w_start_ok) begin
            r_d    <= rand_val;
            r_unit <= '0;
            r_step <= '0;
        end else if ((r_state == c_st_delay) && w_tick) begin
            if (r_unit == c_unit_last) begin
                r_unit <= '0;
                r_step <= r_step + 1'b1;
            end else begin
                r_unit <= r_unit + 1'b1;
            end
        end
    end

    // Reaction counter: zeroed on REACT entry, one count per tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rt <= '0;
        end else if ((r_state == c_st_delay) && (w_state_nxt == c_st_react)) begin
            r_rt <= '0;
        end else if ((r_state == c_st_react) && w_tick) begin
            r_rt <= r_rt + 1'b1;
        end
    end

    // Result capture, single-cycle valid pulse and timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_start_ok) begin
                r_result  <= '0;
                r_timeout <= 1'b0;
            end else if (w_react_hit) begin
                r_result       <= r_rt;
                r_result_valid <= 1'b1;
            end else if ((r_state == c_st_react) && w_rt_sat) begin
                r_result       <= c_rt_max;
                r_timeout      <= 1'b1;
                r_result_valid <= 1'b1;
            end
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
            r_foul <= 1'b0;
        end else begin
            r_led  <= (w_state_nxt == c_st_react);
            r_busy <= (w_state_nxt == c_st_delay) || (w_state_nxt == c_st_react);
            r_foul <= (w_state_nxt == c_st_foul);
        end
    end

    assign led          = r_led;
    assign busy         = r_busy;
    assign foul         = r_foul;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;

`ifdef BEST_TIME_EN
    logic [RT_W-1:0] r_best;
    logic            r_new_best;

    // Best score: only real reactions (never timeouts) can improve it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_best     <= '1;
            r_new_best <= 1'b0;
        end else begin
            r_new_best <= 1'b0;
            if (w_react_hit && (r_rt < r_best)) begin
                r_best     <= r_rt;
                r_new_best <= 1'b1;
            end
        end
    end

    assign best     = r_best;
    assign new_best = r_new_best;
`else
    assign best     = '1;
    assign new_best = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reaction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_sequencer
// Brief    : Self-checking bench for reaction_sequencer with a cycle-count
//            reference model plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_sequencer;

    localparam int TD   = 4;
    localparam int DU   = 2;
    localparam int DW   = 4;
    localparam int RW   = 4;
    localparam int MAXV = 15;

    localparam int P_IDLE  = 0;
    localparam int P_DELAY = 1;
    localparam int P_REACT = 2;
    localparam int P_SHOW  = 3;
    localparam int P_FOUL  = 4;

    logic          clock     = 1'b0;
    logic          reset     = 1'b0;
    logic          start_btn = 1'b0;
    logic          react_btn = 1'b0;
    logic [DW-1:0] rand_val  = '0;
    logic          led;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          foul;
    logic          timeout;
    logic [RW-1:0] best;
    logic          new_best;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 0;

    reaction_sequencer #(
        .TICK_DIV  (TD),
        .DELAY_UNIT(DU),
        .DELAY_W   (DW),
        .RT_W      (RW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .rand_val    (rand_val),
        .led         (led),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .foul        (foul),
        .timeout     (timeout),
        .best        (best),
        .new_best    (new_best)
    );

    always #5 clock = ~clock;

    // Reference model: phase plus cycles elapsed in that phase.
    int m_phase;
    int m_elapsed;
    int m_dlen;
    int m_result;
    int m_best;
    bit m_valid;
    bit m_timeout;
    bit m_newbest;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase   = P_IDLE;
            m_elapsed = 0;
            m_dlen    = 0;
            m_result  = 0;
            m_best    = MAXV;
            m_valid   = 0;
            m_timeout = 0;
            m_newbest = 0;
        end else begin
            m_valid   = 0;
            m_newbest = 0;
            case (m_phase)
                P_DELAY: begin
                    if (react_btn) m_phase = P_FOUL;
                    else if (m_elapsed == m_dlen - 1) begin
                        m_phase   = P_REACT;
                        m_elapsed = 0;
                    end else m_elapsed++;
                end
                P_REACT: begin
                    if (react_btn) begin
                        m_result = m_elapsed / TD;
                        m_valid  = 1;
                        m_phase  = P_SHOW;
`ifdef BEST_TIME_EN
                        if (m_result < m_best) begin
                            m_best    = m_result;
                            m_newbest = 1;
                        end
`endif
                    end else if (m_elapsed == (MAXV + 1) * TD - 1) begin
                        m_result  = MAXV;
                        m_timeout = 1;
                        m_valid   = 1;
                        m_phase   = P_SHOW;
                    end else m_elapsed++;
                end
                default: begin
                    if (start_btn) begin
                        m_phase   = P_DELAY;
                        m_elapsed = 0;
                        m_dlen    = (int'(rand_val) + 1) * DU * TD;
                        m_result  = 0;
                        m_timeout = 0;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (check_en && !reset) begin
            vectors++;
            if (led !== (m_phase == P_REACT) ||
                busy !== (m_phase == P_DELAY || m_phase == P_REACT) ||
                foul !== (m_phase == P_FOUL) ||
                result !== RW'(m_result) || result_valid !== m_valid ||
                timeout !== m_timeout || best !== RW'(m_best) ||
                new_best !== m_newbest) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got led=%b busy=%b foul=%b res=%0d v=%b to=%b best=%0d nb=%b want phase=%0d res=%0d v=%b to=%b best=%0d nb=%b",
                         $time, led, busy, foul, result, result_valid, timeout, best, new_best,
                         m_phase, m_result, m_valid, m_timeout, m_best, m_newbest);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int rv);
        start_btn = 1'b1;
        rand_val  = DW'(rv);
        step();
        start_btn = 1'b0;
    endtask

    task automatic pulse_react();
        react_btn = 1'b1;
        step();
        react_btn = 1'b0;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (led !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int n;
    int res_tab [3] = '{9, 6, 7};
    int best_tab[3];
    int nb_tab  [3];

    initial begin
`ifdef BEST_TIME_EN
        best_tab = '{9, 6, 6};
        nb_tab   = '{1, 1, 0};
`else
        best_tab = '{15, 15, 15};
        nb_tab   = '{0, 0, 0};
`endif
        @(posedge clock);
        #1;
        do_reset();
        check_en = 1;

        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_foul", foul, 0);
        check("rst_timeout", timeout, 0);
        check("rst_best", best, 15);
        check("rst_new_best", new_best, 0);

        // Nominal trial
        pulse_start(3);
        check("nom_busy", busy, 1);
        wait_led(n);
        check("nom_led_latency", n, 32);
        repeat (21) step();
        pulse_react();
        check("nom_result", result, 5);
        check("nom_valid", result_valid, 1);
        check("nom_led_off", led, 0);
        check("nom_busy_off", busy, 0);
        step();
        check("nom_valid_1cyc", result_valid, 0);
        check("nom_result_held", result, 5);

        // False start, then a new start clears foul
        pulse_start(2);
        repeat (10) step();
        pulse_react();
        check("fs_foul", foul, 1);
        check("fs_valid", result_valid, 0);
        repeat (60) step();
        check("fs_led", led, 0);
        pulse_start(1);
        check("fs_foul_clr", foul, 0);
        check("fs_busy", busy, 1);
        check("fs_result_clr", result, 0);

        // Start during DELAY and REACT ignored; then timeout
        repeat (4) step();
        pulse_start(9);
        wait_led(n);
        check("start_ign_delay", n, 11);
        pulse_start(5);
        check("start_ign_react", led, 1);
        repeat (63) step();
        check("to_result", result, 15);
        check("to_timeout", timeout, 1);
        check("to_valid", result_valid, 1);
        pulse_start(0);
        check("to_clr", timeout, 0);

        // React in the final DELAY tick cycle
        repeat (7) step();
        pulse_react();
        check("last_tick_foul", foul, 1);
        check("last_tick_led", led, 0);

        // React in the saturation cycle
        pulse_start(0);
        wait_led(n);
        check("sat_led_latency", n, 8);
        repeat (63) step();
        pulse_react();
        check("sat_result", result, 15);
        check("sat_timeout", timeout, 0);
        check("sat_valid", result_valid, 1);

        // Asynchronous reset mid-REACT
        pulse_start(0);
        wait_led(n);
        repeat (5) step();
        #3 reset = 1'b1;
        #1;
        check("arst_led", led, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_valid", result_valid, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        step();
        check("arst_idle", busy, 0);

        // Best-score sequence from a fresh reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_start(i + 1);
            wait_led(n);
            repeat (res_tab[i] * TD) step();
            pulse_react();
            check("best_result", result, res_tab[i]);
            check("best_value", best, best_tab[i]);
            check("best_pulse", new_best, nb_tab[i]);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start_btn = ($urandom_range(0, 39) == 0);
            react_btn = ($urandom_range(0, 59) == 0);
            rand_val  = DW'($urandom);
            step();
        end
        start_btn = 1'b0;
        react_btn = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
